parallel_serial_cond: RTL

- Transmit side of the comma-aligned serial link: takes 8-bit parallel words over a valid/ready handshake and emits them MSB-first, one bit per CLK, on a single serial line.
- After reset it sends SYNC_WORDS comma words (8'hBC) so the far-end receiver can align. It then inserts a comma whenever no data word is offered at a word boundary.
- Sits between the parallel datapath and the serial pin, mirroring the serial-to-parallel receiver at the other end.

---
 rtl/parallel_serial_cond_pkg.sv | 13 +
 rtl/parallel_serial_cond.sv | 101 ++++++++++
 2 files changed

// File: rtl/parallel_serial_cond_pkg.sv
// Link-level constants and state encoding shared by the transmitter and the
// serial-to-parallel receiver at the far end of the link.
package parallel_serial_cond_pkg;

  localparam int         LINK_WIDTH = 8;
  localparam logic [7:0] LINK_COMMA = 8'hBC;

  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } state_t;

endpackage

// File: rtl/parallel_serial_cond.sv
// Comma-aligned serial transmitter: loads one parallel word every WIDTH clocks
// and shifts it out MSB-first. A comma burst is sent after reset, and a comma
// fills any word slot for which no data word is offered.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   SYNC  | post-reset comma burst; data words are not accepted
//   DATA  | send the offered word at each load edge, else comma fill
module parallel_serial_cond
  import parallel_serial_cond_pkg::*;
#(
  parameter int               WIDTH      = LINK_WIDTH,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(LINK_COMMA),
  parameter int               SYNC_WORDS = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic             DATA_OUT,
  output logic             FRAME_OUT,
  output logic             SYNCED_OUT
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_WORDS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_sync_cnt;
  logic [CW-1:0]    w_sync_cnt_nxt;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_data_out;
  logic             r_frame;
  logic             w_load;
  logic [WIDTH-1:0] w_word;

  // A word boundary is reached when the last bit of the current word is out.
  assign w_load = (r_bit_cnt == BIT_LAST);

  // State register and sync-burst counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= SYNC;
      r_sync_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
    end
  end

  // Next state and word selection at a load edge; comma is the default word.
  always_comb begin
    w_state_nxt    = r_state;
    w_sync_cnt_nxt = r_sync_cnt;
    w_word         = COMMA;
    if (w_load) begin
      if (r_state == SYNC) begin
        w_sync_cnt_nxt = r_sync_cnt + CW'(1);
        if (r_sync_cnt == SYNC_LAST) begin
          w_state_nxt = DATA;
        end
      end else if (VALID_IN) begin
        w_word = DATA_IN;
      end
    end
  end

  // Serializer: load the selected word on a boundary, otherwise shift left.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bit_cnt  <= BIT_LAST;
      r_shreg    <= '0;
      r_data_out <= 1'b0;
      r_frame    <= 1'b0;
    end else if (w_load) begin
      r_bit_cnt  <= '0;
      r_shreg    <= {w_word[WIDTH-2:0], 1'b0};
      r_data_out <= w_word[WIDTH-1];
      r_frame    <= 1'b1;
    end else begin
      r_bit_cnt  <= r_bit_cnt + BW'(1);
      r_shreg    <= {r_shreg[WIDTH-2:0], 1'b0};
      r_data_out <= r_shreg[WIDTH-1];
      r_frame    <= 1'b0;
    end
  end

  // Handshake and status are decoded from registers only, so the source sees
  // no combinational path from VALID_IN back to READY_OUT.
  assign READY_OUT  = (r_state == DATA) && w_load;
  assign SYNCED_OUT = (r_state == DATA);
  assign DATA_OUT   = r_data_out;
  assign FRAME_OUT  = r_frame;

endmodule
